fpu_shared_arbiter: RTL and testbench
=====================================

Name: fpu_shared_arbiter

Overview:
Shares one private FPU instance among NUM_REQ requesters (e.g. cores of a cluster), using round-robin arbitration. It issues at most one operation per cycle into the pipelined FPU and tracks the owner of each in-flight operation in a tag pipeline. It routes each result and its flags back to the issuing requester. It sits between the requester ports and the FPU's Enable/Stall/operand interface.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
FPU_LATENCY, 2, FPU cycles from an enabled issue to a valid Result/Flags (>=1)
ID_W, $clog2(NUM_REQ), requester index width (derived, localparam)

Ports:
Clk_CI  in  1  clock
Rst_RBI  in  1  reset, synchronous, active-low
Stall_SI  in  1  global stall; freezes arbitration, the FPU and the tag pipeline
Req_SI  in  NUM_REQ  per-requester operation request
Operand_a_DI  in  NUM_REQ x 32  operand A per requester
Operand_b_DI  in  NUM_REQ x 32  operand B per requester
RM_SI  in  NUM_REQ x 2  rounding mode per requester
OP_SI  in  NUM_REQ x 4  opcode per requester
Gnt_SO  out  NUM_REQ  one-hot grant; the operation is accepted this cycle
Valid_SO  out  NUM_REQ  one-hot result-valid for the owning requester
Result_DO  out  32  result, broadcast to all requesters
Flags_DO  out  9  flags, broadcast to all requesters
FpuEnable_SO  out  1  FPU enable; high on an issue cycle
FpuStall_SO  out  1  FPU stall, equal to Stall_SI
FpuOperand_a_DO  out  32  muxed operand A
FpuOperand_b_DO  out  32  muxed operand B
FpuRM_SO  out  2  muxed rounding mode
FpuOP_SO  out  4  muxed opcode
FpuResult_DI  in  32  FPU result
FpuFlags_DI  in  9  FPU flags

Behaviour:
- Reset: Rst_RBI is sampled on the rising edge of Clk_CI; reset is synchronous and active-low. On reset:
  - RR pointer = 0
  - tag pipeline valid bits = 0
  - Busy = 0
  - Gnt_SO = Valid_SO = 0
  - FpuEnable_SO = 0
- Eligibility: requester i is eligible when Req_SI[i] & !Busy[i] & !Stall_SI. Busy[i] is set when i is granted and cleared when its result returns. Each requester therefore has at most one operation in flight.
- Arbitration:
  - Combinational round-robin selection among eligible requesters, starting at the RR pointer.
  - Gnt_SO is one-hot or zero, in the same cycle as Req_SI.
  - On a grant to index g, the pointer becomes (g+1) mod NUM_REQ at the next edge. With no grant, the pointer holds.
- Issue: when any grant is given, FpuEnable_SO = 1 and the Fpu* operand, RM and OP outputs carry the granted requester's inputs. With no grant they drive 0.
- Tag pipeline:
  - FPU_LATENCY stages of {valid, id}. Stage 0 loads {grant_any, g} each non-stalled cycle.
  - Stages shift when Stall_SI = 0 and hold when Stall_SI = 1.
  - Latency: the result is valid exactly FPU_LATENCY non-stalled cycles after the grant cycle.
- Return:
  - When the last stage is valid and Stall_SI = 0, Valid_SO[id] = 1 for one cycle and Busy[id] is cleared at that edge.
  - Result_DO and Flags_DO pass FpuResult_DI and FpuFlags_DI through combinationally.
  - There is no back-pressure: the requester must accept the result in that cycle.
- Stall:
  - Valid_SO is forced to 0 during a stall.
  - A pending last-stage result is delivered on the first non-stalled cycle.
  - No grants are given during a stall.
- Simultaneous grant and return, same requester: the return clears Busy and the new grant sets it. Set wins, so Busy remains 1.
  - The requester is not eligible in that cycle anyway, because Busy is still 1 when eligibility is evaluated. It may be granted from the next cycle.
- Back-to-back issue: a new grant is possible every cycle to different requesters, giving a throughput of 1 operation per cycle.
- All requesters busy: no grant is given and FpuEnable_SO = 0.
- Reset mid-operation: in-flight operations are dropped with no Valid_SO, and all Busy bits are cleared.
- Pointer wrap: after a grant to NUM_REQ-1, the pointer returns to 0.

Decomposition:
- Package fpu_arb_pkg:
  - FPU_OP_W=4, FPU_RM_W=2, FPU_FLAGS_W=9 constants
  - typedef fpu_req_t {op_a, op_b, rm, op}
  - typedef tag_t {valid, id}
- Sub-module rr_arbiter (parameter NUM_REQ): inputs are the eligible mask and the pointer; outputs are the one-hot grant and the encoded index. It also holds the pointer register, with an update enable.

Test Plan:
- Single request, no stall: Req_SI=0001, OP=add, a=0x3F800000, b=0x40000000 -> Gnt_SO=0001 in the same cycle; Valid_SO=0001 two cycles later (FPU_LATENCY=2); Result_DO=0x40400000.
- All four requesting continuously from reset -> grants 0001,0010,0100,1000 on consecutive cycles; Valid_SO follows the same order, offset by 2 cycles. Requester 0 is re-granted only after its Valid_SO.
- Stall_SI=1 for 3 cycles, one cycle after a grant to req 2 -> no grants and Valid_SO=0 during the stall; Valid_SO=0100 arrives 1 cycle after the stall deasserts, 5 cycles after the grant.
- Requester 1 holds Req_SI while busy -> no second grant until its result returns. Requester 3, also requesting, is granted in the intervening cycles.
- Reset asserted with 2 operations in flight -> no Valid_SO after reset; Busy=0; the first grant after reset goes to the lowest eligible index starting at pointer 0.
- Pointer wrap: grant to requester 3 with only requesters 0 and 3 requesting -> next grant goes to requester 0.

Source files
------------

// File: rtl/fpu_arb_pkg.sv
// Shared types and widths for the FPU sharing arbiter.
package fpu_arb_pkg;

    localparam int FPU_DATA_W  = 32;
    localparam int FPU_OP_W    = 4;
    localparam int FPU_RM_W    = 2;
    localparam int FPU_FLAGS_W = 9;

    // Wide enough for the largest supported requester count (16).
    localparam int MAX_ID_W    = 4;

    // One operation as presented to the FPU.
    typedef struct packed {
        logic [FPU_DATA_W-1:0] op_a;
        logic [FPU_DATA_W-1:0] op_b;
        logic [FPU_RM_W-1:0]   rm;
        logic [FPU_OP_W-1:0]   op;
    } fpu_req_t;

    // Ownership tag travelling alongside an operation inside the FPU.
    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

    // Builds a tag from an issue decision; the id is zero-extended.
    function automatic tag_t tag_make(input logic valid, input logic [MAX_ID_W-1:0] id);
        tag_t t;
        t.valid = valid;
        t.id    = id;
        return t;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first eligible index at or after the
// pointer, and advances the pointer past the winner when enabled.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic               clk_sys,
    input  logic               rst_b,
    input  logic [NUM_REQ-1:0] eligible,
    input  logic               upd_en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_any
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W:0]   cand;

    // Scan from the pointer with wrap-around; the first eligible index wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!gnt_any && eligible[cand[ID_W-1:0]]) begin
                gnt[cand[ID_W-1:0]] = 1'b1;
                gnt_idx             = cand[ID_W-1:0];
                gnt_any             = 1'b1;
            end
        end
    end

    // Pointer moves to the index after the winner; it holds with no grant.
    always_ff @(posedge clk_sys) begin
        if (!rst_b) begin
            ptr_q <= '0;
        end else if (upd_en && gnt_any) begin
            if (gnt_idx == ID_W'(NUM_REQ-1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= gnt_idx + ID_W'(1);
            end
        end
    end

endmodule

// File: rtl/fpu_shared_arbiter.sv
// Shares one pipelined FPU among NUM_REQ requesters. Issues at most one
// operation per cycle, tags each in-flight operation with its owner and
// routes the returning result to that owner.
module fpu_shared_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int FPU_LATENCY = 2
) (
    input  logic                                Clk_CI,
    input  logic                                Rst_RBI,
    input  logic                                Stall_SI,
    input  logic [NUM_REQ-1:0]                  Req_SI,
    input  logic [NUM_REQ-1:0][FPU_DATA_W-1:0]  Operand_a_DI,
    input  logic [NUM_REQ-1:0][FPU_DATA_W-1:0]  Operand_b_DI,
    input  logic [NUM_REQ-1:0][FPU_RM_W-1:0]    RM_SI,
    input  logic [NUM_REQ-1:0][FPU_OP_W-1:0]    OP_SI,
    output logic [NUM_REQ-1:0]                  Gnt_SO,
    output logic [NUM_REQ-1:0]                  Valid_SO,
    output logic [FPU_DATA_W-1:0]               Result_DO,
    output logic [FPU_FLAGS_W-1:0]              Flags_DO,
    output logic                                FpuEnable_SO,
    output logic                                FpuStall_SO,
    output logic [FPU_DATA_W-1:0]               FpuOperand_a_DO,
    output logic [FPU_DATA_W-1:0]               FpuOperand_b_DO,
    output logic [FPU_RM_W-1:0]                 FpuRM_SO,
    output logic [FPU_OP_W-1:0]                 FpuOP_SO,
    input  logic [FPU_DATA_W-1:0]               FpuResult_DI,
    input  logic [FPU_FLAGS_W-1:0]              FpuFlags_DI
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] busy_q;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] ret_mask;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    fpu_req_t           issue;
    tag_t               tag_q [FPU_LATENCY];
    tag_t               tag_last;

    // Nothing is granted while stalled or while reset is being applied,
    // and a requester with an operation in flight must wait for its result.
    assign eligible = Req_SI & ~busy_q & {NUM_REQ{~Stall_SI & Rst_RBI}};

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk_sys  (Clk_CI),
        .rst_b    (Rst_RBI),
        .eligible (eligible),
        .upd_en   (~Stall_SI),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_any  (gnt_any)
    );

    // Operand mux driven by the one-hot grant; all zero when idle.
    always_comb begin
        issue = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                issue.op_a = Operand_a_DI[i];
                issue.op_b = Operand_b_DI[i];
                issue.rm   = RM_SI[i];
                issue.op   = OP_SI[i];
            end
        end
    end

    assign tag_last = tag_q[FPU_LATENCY-1];

    // Decode the owner of the operation leaving the FPU this cycle.
    always_comb begin
        ret_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tag_last.valid && !Stall_SI && Rst_RBI && (tag_last.id == MAX_ID_W'(i))) begin
                ret_mask[i] = 1'b1;
            end
        end
    end

    // Tag pipeline mirrors the FPU: shifts on non-stalled cycles only.
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            for (int s = 0; s < FPU_LATENCY; s++) begin
                tag_q[s] <= '0;
            end
        end else if (!Stall_SI) begin
            tag_q[0] <= tag_make(gnt_any, MAX_ID_W'(gnt_idx));
            for (int s = 1; s < FPU_LATENCY; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    // Busy tracking; a grant in the same cycle as a return keeps the bit set.
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~ret_mask) | gnt;
        end
    end

    assign Gnt_SO          = gnt;
    assign Valid_SO        = ret_mask;
    assign Result_DO       = FpuResult_DI;
    assign Flags_DO        = FpuFlags_DI;
    assign FpuEnable_SO    = gnt_any;
    assign FpuStall_SO     = Stall_SI;
    assign FpuOperand_a_DO = issue.op_a;
    assign FpuOperand_b_DO = issue.op_b;
    assign FpuRM_SO        = issue.rm;
    assign FpuOP_SO        = issue.op;

endmodule

// File: tb/tb_fpu_shared_arbiter.sv
// Directed bench for the FPU sharing arbiter (NUM_REQ=4, FPU_LATENCY=2).
module tb_fpu_shared_arbiter;

    logic              clk;
    logic              rst_b;
    logic              stall;
    logic [3:0]        req;
    logic [3:0][31:0]  opa;
    logic [3:0][31:0]  opb;
    logic [3:0][1:0]   rm;
    logic [3:0][3:0]   op;
    logic [3:0]        gnt;
    logic [3:0]        valid;
    logic [31:0]       result;
    logic [8:0]        flags;
    logic              fpu_en;
    logic              fpu_stall;
    logic [31:0]       fpu_a;
    logic [31:0]       fpu_b;
    logic [1:0]        fpu_rm;
    logic [3:0]        fpu_op;
    logic [31:0]       fpu_res;
    logic [8:0]        fpu_flags;

    int checks   = 0;
    int failures = 0;

    fpu_shared_arbiter #(
        .NUM_REQ     (4),
        .FPU_LATENCY (2)
    ) dut (
        .Clk_CI          (clk),
        .Rst_RBI         (rst_b),
        .Stall_SI        (stall),
        .Req_SI          (req),
        .Operand_a_DI    (opa),
        .Operand_b_DI    (opb),
        .RM_SI           (rm),
        .OP_SI           (op),
        .Gnt_SO          (gnt),
        .Valid_SO        (valid),
        .Result_DO       (result),
        .Flags_DO        (flags),
        .FpuEnable_SO    (fpu_en),
        .FpuStall_SO     (fpu_stall),
        .FpuOperand_a_DO (fpu_a),
        .FpuOperand_b_DO (fpu_b),
        .FpuRM_SO        (fpu_rm),
        .FpuOP_SO        (fpu_op),
        .FpuResult_DI    (fpu_res),
        .FpuFlags_DI     (fpu_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_b     = 1'b0;
        stall     = 1'b0;
        req       = 4'b0000;
        fpu_res   = 32'h0;
        fpu_flags = 9'h0;
        opa[0] = 32'h3F80_0000; opb[0] = 32'h4000_0000; rm[0] = 2'd0; op[0] = 4'd0;
        opa[1] = 32'h1111_1111; opb[1] = 32'hA1A1_A1A1; rm[1] = 2'd1; op[1] = 4'd1;
        opa[2] = 32'h2222_2222; opb[2] = 32'hA2A2_A2A2; rm[2] = 2'd2; op[2] = 4'd2;
        opa[3] = 32'h3333_3333; opb[3] = 32'hA3A3_A3A3; rm[3] = 2'd3; op[3] = 4'd3;
        tick();
        tick();

        // Reset held with all requesting: nothing granted or returned.
        req = 4'b1111;
        #2;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_valid", valid, 4'b0000);
        chk("rst_en", fpu_en, 1'b0);
        tick();

        // Single add from requester 0.
        rst_b = 1'b1;
        req   = 4'b0001;
        #2;
        chk("single_gnt", gnt, 4'b0001);
        chk("single_en", fpu_en, 1'b1);
        chk("single_a", fpu_a, 32'h3F80_0000);
        chk("single_b", fpu_b, 32'h4000_0000);
        chk("single_op", fpu_op, 4'd0);
        tick();
        #2;
        chk("single_busy_gnt", gnt, 4'b0000);
        chk("single_idle_en", fpu_en, 1'b0);
        chk("single_idle_a", fpu_a, 32'h0);
        chk("single_early_valid", valid, 4'b0000);
        tick();
        fpu_res   = 32'h4040_0000;
        fpu_flags = 9'h1A5;
        #2;
        chk("single_valid", valid, 4'b0001);
        chk("single_result", result, 32'h4040_0000);
        chk("single_flags", flags, 9'h1A5);
        chk("single_ret_gnt", gnt, 4'b0000);
        tick();
        req     = 4'b0000;
        fpu_res = 32'h0;
        #2;
        chk("single_after_valid", valid, 4'b0000);
        tick();

        // Fresh reset, then all four request continuously.
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        req   = 4'b1111;
        #2; chk("all_k0_gnt", gnt, 4'b0001);
        tick();
        #2; chk("all_k1_gnt", gnt, 4'b0010); chk("all_k1_valid", valid, 4'b0000);
        tick();
        #2; chk("all_k2_gnt", gnt, 4'b0100); chk("all_k2_valid", valid, 4'b0001);
        chk("all_k2_a", fpu_a, 32'h2222_2222); chk("all_k2_b", fpu_b, 32'hA2A2_A2A2);
        chk("all_k2_op", fpu_op, 4'd2); chk("all_k2_rm", fpu_rm, 2'd2);
        tick();
        #2; chk("all_k3_gnt", gnt, 4'b1000); chk("all_k3_valid", valid, 4'b0010);
        tick();
        #2; chk("all_k4_gnt", gnt, 4'b0001); chk("all_k4_valid", valid, 4'b0100);
        tick();
        #2; chk("all_k5_gnt", gnt, 4'b0010); chk("all_k5_valid", valid, 4'b1000);
        tick();
        req = 4'b0000;
        #2; chk("all_k6_valid", valid, 4'b0001); chk("all_k6_gnt", gnt, 4'b0000);
        tick();
        #2; chk("all_k7_valid", valid, 4'b0010);
        tick();

        // Stall for 3 cycles right after a grant to requester 2.
        req = 4'b0100;
        #2; chk("stall_s0_gnt", gnt, 4'b0100);
        tick();
        req   = 4'b1000;
        stall = 1'b1;
        #2; chk("stall_s1_gnt", gnt, 4'b0000); chk("stall_s1_valid", valid, 4'b0000);
        chk("stall_s1_fpustall", fpu_stall, 1'b1); chk("stall_s1_en", fpu_en, 1'b0);
        tick();
        #2; chk("stall_s2_gnt", gnt, 4'b0000); chk("stall_s2_valid", valid, 4'b0000);
        tick();
        #2; chk("stall_s3_gnt", gnt, 4'b0000); chk("stall_s3_valid", valid, 4'b0000);
        tick();
        stall = 1'b0;
        req   = 4'b0000;
        #2; chk("stall_s4_valid", valid, 4'b0000); chk("stall_s4_fpustall", fpu_stall, 1'b0);
        tick();
        #2; chk("stall_s5_valid", valid, 4'b0100);
        tick();

        // Requester 1 holds its request while busy; requester 3 interleaves.
        req = 4'b1010;
        #2; chk("hold_t0_gnt", gnt, 4'b1000);
        tick();
        #2; chk("hold_t1_gnt", gnt, 4'b0010);
        tick();
        #2; chk("hold_t2_gnt", gnt, 4'b0000); chk("hold_t2_valid", valid, 4'b1000);
        tick();
        #2; chk("hold_t3_gnt", gnt, 4'b1000); chk("hold_t3_valid", valid, 4'b0010);
        tick();
        #2; chk("hold_t4_gnt", gnt, 4'b0010); chk("hold_t4_valid", valid, 4'b0000);
        tick();
        req = 4'b0000;
        #2; chk("hold_t5_valid", valid, 4'b1000);
        tick();
        #2; chk("hold_t6_valid", valid, 4'b0010);
        tick();

        // Reset with two operations in flight.
        req = 4'b0011;
        #2; chk("rmid_r0_gnt", gnt, 4'b0001);
        tick();
        #2; chk("rmid_r1_gnt", gnt, 4'b0010);
        tick();
        rst_b = 1'b0;
        #2; chk("rmid_r2_gnt", gnt, 4'b0000); chk("rmid_r2_valid", valid, 4'b0000);
        tick();
        rst_b = 1'b1;
        req   = 4'b0000;
        #2; chk("rmid_r3_valid", valid, 4'b0000);
        tick();
        #2; chk("rmid_r4_valid", valid, 4'b0000);
        tick();
        req = 4'b1010;
        #2; chk("rmid_r5_gnt", gnt, 4'b0010);
        tick();
        req = 4'b0001;
        #2; chk("rmid_r6_gnt", gnt, 4'b0001);
        tick();
        req = 4'b0000;
        #2; chk("rmid_r7_valid", valid, 4'b0010);
        tick();
        #2; chk("rmid_r8_valid", valid, 4'b0001);
        tick();

        // Pointer wrap after a grant to requester 3.
        req = 4'b1001;
        #2; chk("wrap_w0_gnt", gnt, 4'b1000);
        tick();
        req = 4'b1011;
        #2; chk("wrap_w1_gnt", gnt, 4'b0001);
        tick();
        req = 4'b0000;
        #2; chk("wrap_w2_valid", valid, 4'b1000);
        tick();
        #2; chk("wrap_w3_valid", valid, 4'b0001);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
